fifo_stream_reader: RTL and testbench

Read-side controller for the team's 32-bit synchronous FIFO. It drains words through the FIFO read port (`r_en` / `data_out` / `empty`) and presents them on a valid/ready output stream. A small skid buffer absorbs the FIFO's one-cycle read latency, so full throughput is sustained when the downstream consumer stalls. It sits between the FIFO and any streaming consumer, and is the counterpart of the writer that fills the FIFO.

---
 rtl/fifo_stream_reader.sv | 101 ++++++++++
 tb/tb_fifo_stream_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side controller: drains a synchronous FIFO into a valid/ready stream through a small skid buffer.
// Optional burst marking (m_last) is built when READER_LAST_EN is defined.
module fifo_stream_reader #(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
`ifdef READER_LAST_EN
  output logic              m_last,
`endif
  output logic [CNT_W-1:0]  word_cnt,
  output logic              idle
);

  localparam int PTR_W = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [OCC_W:0]   DEPTH_C = (OCC_W+1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(BUF_DEPTH - 1);

  generate
    if (BUF_DEPTH < 2 || BURST_LEN < 1) begin : g_bad_cfg
      $error("fifo_stream_reader: BUF_DEPTH must be >= 2 and BURST_LEN >= 1");
    end
  endgenerate

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              rd_pend;
  logic              pop;
  logic [OCC_W:0]    fill_after;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign pop = m_valid & m_ready;

  // Words already committed (buffered + in flight) once this cycle's pop retires;
  // a new read is only issued if it is guaranteed a free slot.
  assign fill_after = (OCC_W+1)'(occ) + (OCC_W+1)'(rd_pend) - (OCC_W+1)'(pop);
  assign fifo_r_en  = en & ~flush & ~rst & ~fifo_empty & (fill_after < DEPTH_C);

  assign m_valid = (occ != '0);
  assign m_data  = mem[rd_ptr];
  assign idle    = (occ == '0) & ~rd_pend & fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      rd_pend  <= 1'b0;
      word_cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) word_cnt <= word_cnt + 1'b1;
      if (flush) begin
        // A word landing from last cycle's read is dropped along with the buffer.
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        occ     <= '0;
        rd_pend <= 1'b0;
      end else begin
        rd_pend <= fifo_r_en;
        if (rd_pend) begin
          mem[wr_ptr] <= fifo_data;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        occ <= fill_after[OCC_W-1:0];
      end
    end
  end

`ifdef READER_LAST_EN
  localparam int POS_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(BURST_LEN - 1);

  logic [POS_W-1:0] pos;

  always_ff @(posedge clk) begin
    if (rst || flush) pos <= '0;
    else if (pop)     pos <= (pos == LAST_POS) ? '0 : pos + 1'b1;
  end

  assign m_last = m_valid & (pos == LAST_POS);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: queue-based FIFO + stream model, directed phases and random traffic.
module tb_fifo_stream_reader;
  localparam int DW = 32, BD = 2, CW = 16, BL = 8;

  logic          clk = 1'b0;
  logic          rst, en, flush, fifo_r_en, fifo_empty, m_valid, m_ready, idle;
  logic [DW-1:0] fifo_data, m_data;
  logic [CW-1:0] word_cnt;
`ifdef READER_LAST_EN
  logic          m_last;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(DW), .BUF_DEPTH(BD), .CNT_W(CW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .fifo_r_en(fifo_r_en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef READER_LAST_EN
    .m_last(m_last),
`endif
    .word_cnt(word_cnt), .idle(idle)
  );

  typedef struct { logic [DW-1:0] d; int age; } ent_t;

  int            checks = 0, errors = 0;
  logic [DW-1:0] fq[$];      // FIFO contents
  ent_t          exq[$];     // words read from the FIFO and not yet delivered, oldest first
  logic [DW-1:0] got[$];     // delivered words
  logic          lastq[$];   // m_last seen with each delivered word
  logic [CW-1:0] cnt_m = '0;
  int            pos_m = 0, rds = 0, pops = 0, vlds = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
    fifo_empty = (fq.size() == 0);
  endtask

  // One clock: compare outputs before the edge, then advance FIFO and model after it.
  task automatic step();
    logic ev, er, pop;
    int   outst;
    ent_t e;
    @(negedge clk);
    outst = exq.size();
    ev    = (outst > 0) && (exq[0].age >= 1);
    pop   = ev && m_ready;
    er    = en && !flush && !rst && (fq.size() != 0) && ((outst - (pop ? 1 : 0)) < BD);
    chk("m_valid", m_valid, ev);
    chk("fifo_r_en", fifo_r_en, er);
    chk("idle", idle, (outst == 0) && fifo_empty);
    chk("word_cnt", word_cnt, cnt_m);
    if (ev) chk("m_data", m_data, exq[0].d);
`ifdef READER_LAST_EN
    chk("m_last", m_last, ev && (pos_m == BL - 1));
    if (pop && !rst) lastq.push_back(m_last);
`endif
    if (pop && !rst) begin got.push_back(exq[0].d); pops++; end
    if (er) rds++;
    if (ev) vlds++;
    @(posedge clk);
    #1;
    if (rst) begin
      exq.delete();
      cnt_m = '0;
      pos_m = 0;
    end else begin
      if (pop) cnt_m++;
      if (flush) begin
        exq.delete();
        pos_m = 0;
      end else begin
        if (pop) begin
          void'(exq.pop_front());
          pos_m = (pos_m + 1) % BL;
        end
        foreach (exq[i]) exq[i].age++;
      end
    end
    if (er) begin
      fifo_data = fq.pop_front();
      e.d = fifo_data;
      e.age = 0;
      exq.push_back(e);
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (!(exq.size() == 0 && fq.size() == 0) && n < 300) begin step(); n++; end
    chk({nm, "_drain_timeout"}, n < 300, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; m_ready = 1'b1;
    fifo_data = '0; fifo_empty = 1'b1;
    push_words(32'hA000_0000, 32);
    @(posedge clk); #1;

    // reset held with FIFO non-empty
    step(); step();
    chk("rst_m_data", m_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_m_valid", m_valid, 0);

    // streaming 32 words
    rst = 1'b0; got.delete(); vlds = 0;
    drain("stream");
    step();
    chk("stream_valid_cycles", vlds, 32);
    chk("stream_count", got.size(), 32);
    foreach (got[i]) chk("stream_order", got[i], 32'hA000_0000 + i);
    chk("stream_word_cnt", word_cnt, 32);
    chk("stream_idle", idle, 1);

    // backpressure: 10 stalled cycles read only BD words
    m_ready = 1'b0; rds = 0;
    push_words(32'hA000_0000, 5);
    repeat (10) step();
    chk("bp_reads", rds, 2);
    chk("bp_hold_data", m_data, 32'hA000_0000);
    chk("bp_hold_valid", m_valid, 1);
    m_ready = 1'b1; got.delete(); pops = 0;
    repeat (5) step();
    chk("bp_no_gap", pops, 5);
    drain("bp");
    chk("bp_count", got.size(), 5);
    foreach (got[i]) chk("bp_order", got[i], 32'hA000_0000 + i);

    // alternating ready over 16 words
    got.delete();
    push_words(32'hC000_0000, 16);
    for (int i = 0; i < 40; i++) begin m_ready = i[0]; step(); end
    m_ready = 1'b1;
    drain("alt");
    chk("alt_count", got.size(), 16);
    foreach (got[i]) chk("alt_order", got[i], 32'hC000_0000 + i);
    chk("alt_word_cnt", word_cnt, 53);

    // flush with a full skid buffer
    m_ready = 1'b0;
    push_words(32'hD000_0000, 6);
    repeat (4) step();
    chk("flush_pre_valid", m_valid, 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_valid_drop", m_valid, 0);
    chk("flush_cnt_kept", word_cnt, 53);
    m_ready = 1'b1; got.delete();
    drain("flush");
    chk("flush_count", got.size(), 4);
    if (got.size() > 0) chk("flush_next_word", got[0], 32'hD000_0002);
    chk("flush_word_cnt", word_cnt, 57);

`ifdef READER_LAST_EN
    rst = 1'b1; step(); rst = 1'b0;
    lastq.delete();
    push_words(32'hE000_0000, 16);
    drain("last");
    chk("last_count", lastq.size(), 16);
    foreach (lastq[i]) chk("last_pos", lastq[i], (i == 7) || (i == 15));
`endif

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 20) push_words($urandom, $urandom_range(1, 3));
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 49) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; en = 1'b1; m_ready = 1'b1;
    drain("rand");
    step();
    chk("rand_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
